// File: rtl/imem_loader_if.sv
// imem_loader_if: bundles the program-word stream, the load control/status
// signals and the byte write port of the instruction-memory loader.
//   master : program source / system controller (drives start, word_count,
//            in_valid, in_data; observes everything else)
//   slave  : the loader itself
// Parameter CNT_W sets the width of word_count.
interface imem_loader_if #(
    parameter int unsigned CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] word_count;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             wr_en;
    logic [63:0]      wr_addr;
    logic [7:0]       wr_byte;
    logic             busy;
    logic             done;
    logic             err;
    logic             cpu_hold;
    logic [31:0]      checksum;

    modport master (
        output start, word_count, in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_byte, busy, done, err, cpu_hold, checksum
    );

    modport slave (
        input  start, word_count, in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_byte, busy, done, err, cpu_hold, checksum
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the byte-addressed instruction memory.
// Accepts 32-bit words on a valid/ready stream and emits four little-endian
// byte writes per word starting at address 0, holding the CPU in reset
// (cpu_hold) until the image is complete.
// Ports:
//   clk   - system clock, rising edge
//   reset - asynchronous, active-high
//   bus   - imem_loader_if.slave: start/word_count control, in_* stream,
//           wr_* byte write port, busy/done/err/cpu_hold status, checksum
// Parameters: MEM_BYTES (memory size, multiple of 4), CNT_W (word counter width).
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN enables the running
// modulo-2^32 word sum on checksum; when undefined checksum is constant 0.
module imem_loader #(
    parameter int unsigned MEM_BYTES = 168,
    parameter int unsigned CNT_W     = 16
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    localparam int unsigned ADDR_W = 64;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_WORD = 2'd1,
        S_WRITE     = 2'd2,
        S_DONE      = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_remaining;
    logic [31:0]       r_word;
    logic [1:0]        r_bi;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_byte;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic              r_cpu_hold;

    logic              w_fits;
    logic [7:0]        w_cur_byte;

    // Next word fits only if all four of its bytes land below MEM_BYTES.
    assign w_fits       = (r_addr + ADDR_W'(4)) <= ADDR_W'(MEM_BYTES);
    assign bus.in_ready = (r_state == S_WAIT_WORD) && w_fits;

    // Byte lane of the latched word selected by the byte index.
    assign w_cur_byte = 8'(r_word >> {r_bi, 3'b000});

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;
    assign bus.checksum = r_checksum;
`else
    assign bus.checksum = 32'd0;
`endif

    // Byte 0 is emitted on the handshake edge itself, so WRITE spends its
    // first three cycles issuing bytes 1..3 and its fourth (bi wrapped to 0)
    // retiring the word while byte 3 is on the outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_word      <= '0;
            r_bi        <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_byte   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_hold  <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_checksum  <= '0;
`endif
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_remaining <= bus.word_count;
                        r_addr      <= '0;
                        r_err       <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_checksum  <= '0;
`endif
                        if (bus.word_count == '0) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state    <= S_WAIT_WORD;
                            r_done     <= 1'b0;
                            r_busy     <= 1'b1;
                            r_cpu_hold <= 1'b1;
                        end
                    end
                end
                S_WAIT_WORD: begin
                    if (!w_fits) begin
                        r_state    <= S_DONE;
                        r_err      <= 1'b1;
                        r_done     <= 1'b1;
                        r_busy     <= 1'b0;
                        r_cpu_hold <= 1'b0;
                    end else if (bus.in_valid) begin
                        r_word    <= bus.in_data;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_byte <= bus.in_data[7:0];
                        r_addr    <= r_addr + ADDR_W'(1);
                        r_bi      <= 2'd1;
                        r_state   <= S_WRITE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_checksum <= r_checksum + bus.in_data;
`endif
                    end
                end
                S_WRITE: begin
                    if (r_bi != 2'd0) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_addr;
                        r_wr_byte <= w_cur_byte;
                        r_addr    <= r_addr + ADDR_W'(1);
                        r_bi      <= r_bi + 2'd1;
                    end else begin
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_busy     <= 1'b0;
                            r_cpu_hold <= 1'b0;
                        end else begin
                            r_state <= S_WAIT_WORD;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.wr_en    = r_wr_en;
    assign bus.wr_addr  = r_wr_addr;
    assign bus.wr_byte  = r_wr_byte;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;
    assign bus.cpu_hold = r_cpu_hold;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
// A byte-write monitor captures every write into a shadow memory; each test
// task drives its scenario and compares against hand-computed values.
module tb_imem_loader;
    localparam int unsigned MEM_BYTES = 168;
    localparam int unsigned CNT_W     = 16;

    logic clk;
    logic reset;

    int checks;
    int errors;

    logic [7:0] mem [0:255];
    int         wr_cnt;
    logic [63:0] last_addr;

    imem_loader_if #(.CNT_W(CNT_W)) bus ();

    imem_loader #(
        .MEM_BYTES(MEM_BYTES),
        .CNT_W    (CNT_W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shadow memory of all issued byte writes.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            if (bus.wr_addr < 64'd256) mem[bus.wr_addr[7:0]] = bus.wr_byte;
            wr_cnt    = wr_cnt + 1;
            last_addr = bus.wr_addr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        for (int a = 0; a < 256; a++) mem[a] = 8'h00;
        wr_cnt    = 0;
        last_addr = '0;
    endtask

    task automatic pulse_start(input int unsigned n);
        bus.start      = 1'b1;
        bus.word_count = CNT_W'(n);
        step();
        bus.start      = 1'b0;
    endtask

    function automatic logic [31:0] word_of(input int k, input bit custom);
        if (custom) return (k == 0) ? 32'h00900413 : 32'h00000493;
        return {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
    endfunction

    // Streams words with in_valid held high until done; optionally pulses
    // start (with a different count) in the middle of the first WRITE.
    task automatic feed(input bit custom, input bit glitch,
                        output int hs, output int gap_bad, output bit timed_out);
        int last_hs;
        bit glitched;
        bit hs_now;
        hs = 0; gap_bad = 0; timed_out = 1'b1; last_hs = -1; glitched = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            if (bus.done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = word_of(hs, custom);
            bus.start    = 1'b0;
            if (glitch && !glitched && bus.wr_en === 1'b1 && bus.wr_addr == 64'd1) begin
                bus.start      = 1'b1;
                bus.word_count = CNT_W'(9);
                glitched       = 1'b1;
            end
            hs_now = (bus.in_ready === 1'b1);
            step();
            if (hs_now) begin
                if (last_hs >= 0 && (c - last_hs) != 5) gap_bad++;
                last_hs = c;
                hs++;
            end
        end
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        checks++; if (bus.wr_en !== 1'b0 || bus.wr_addr !== 64'd0 || bus.wr_byte !== 8'd0) begin
            errors++; $display("FAIL reset_wr: wr_en=%b addr=%0d byte=%h expected 0/0/00", bus.wr_en, bus.wr_addr, bus.wr_byte); end
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.cpu_hold !== 1'b1) begin
            errors++; $display("FAIL reset_status: busy=%b done=%b err=%b hold=%b expected 0/0/0/1", bus.busy, bus.done, bus.err, bus.cpu_hold); end
        reset = 1'b0;
        step();
        checks++; if (bus.in_ready !== 1'b0 || bus.checksum !== 32'd0) begin
            errors++; $display("FAIL reset_idle: in_ready=%b checksum=%h expected 0/0", bus.in_ready, bus.checksum); end
    endtask

    task automatic test_zero_count();
        clear_mon();
        pulse_start(0);
        checks++; if (bus.done !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL zero_done: done=%b hold=%b busy=%b expected 1/0/0", bus.done, bus.cpu_hold, bus.busy); end
        step(); step();
        checks++; if (wr_cnt !== 0) begin
            errors++; $display("FAIL zero_nowrite: writes=%0d expected 0", wr_cnt); end
    endtask

    task automatic test_single_word();
        logic [31:0] w;
        logic [7:0]  eb;
        w = 32'h00000013;
        clear_mon();
        pulse_start(1);
        checks++; if (bus.busy !== 1'b1 || bus.in_ready !== 1'b1 || bus.done !== 1'b0 || bus.cpu_hold !== 1'b1) begin
            errors++; $display("FAIL single_wait: busy=%b ready=%b done=%b hold=%b expected 1/1/0/1", bus.busy, bus.in_ready, bus.done, bus.cpu_hold); end
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        step();
        bus.in_valid = 1'b0;
        bus.in_data  = 32'hDEADBEEF;
        for (int i = 0; i < 4; i++) begin
            eb = 8'(w >> (8*i));
            checks++; if (bus.wr_en !== 1'b1 || bus.wr_addr !== 64'(i) || bus.wr_byte !== eb) begin
                errors++; $display("FAIL single_byte%0d: wr_en=%b addr=%0d byte=%h expected 1/%0d/%h", i, bus.wr_en, bus.wr_addr, bus.wr_byte, i, eb); end
            step();
        end
        checks++; if (bus.wr_en !== 1'b0 || bus.done !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL single_done: wr_en=%b done=%b hold=%b busy=%b expected 0/1/0/0", bus.wr_en, bus.done, bus.cpu_hold, bus.busy); end
    endtask

    task automatic test_full_image();
        int hs, gap_bad, bad;
        bit to;
        clear_mon();
        pulse_start(42);
        feed(1'b0, 1'b0, hs, gap_bad, to);
        checks++; if (to !== 1'b0 || hs !== 42 || gap_bad !== 0) begin
            errors++; $display("FAIL full_stream: timeout=%b words=%0d gap_errs=%0d expected 0/42/0", to, hs, gap_bad); end
        checks++; if (wr_cnt !== 168 || last_addr !== 64'd167) begin
            errors++; $display("FAIL full_writes: writes=%0d last=%0d expected 168/167", wr_cnt, last_addr); end
        bad = 0;
        for (int a = 0; a < 168; a++) if (mem[a] !== 8'(a)) bad++;
        checks++; if (bad !== 0) begin
            errors++; $display("FAIL full_data: wrong_bytes=%0d expected 0", bad); end
        checks++; if (bus.err !== 1'b0 || bus.cpu_hold !== 1'b0 || bus.done !== 1'b1) begin
            errors++; $display("FAIL full_status: err=%b hold=%b done=%b expected 0/0/1", bus.err, bus.cpu_hold, bus.done); end
    endtask

    task automatic test_overflow();
        int hs, gap_bad;
        bit to;
        clear_mon();
        pulse_start(43);
        feed(1'b0, 1'b0, hs, gap_bad, to);
        checks++; if (to !== 1'b0 || hs !== 42 || wr_cnt !== 168) begin
            errors++; $display("FAIL ovf_words: timeout=%b words=%0d writes=%0d expected 0/42/168", to, hs, wr_cnt); end
        checks++; if (bus.done !== 1'b1 || bus.err !== 1'b1 || bus.cpu_hold !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++; $display("FAIL ovf_status: done=%b err=%b hold=%b ready=%b expected 1/1/0/0", bus.done, bus.err, bus.cpu_hold, bus.in_ready); end
        pulse_start(1);
        checks++; if (bus.err !== 1'b0 || bus.done !== 1'b0 || bus.cpu_hold !== 1'b1) begin
            errors++; $display("FAIL ovf_restart: err=%b done=%b hold=%b expected 0/0/1", bus.err, bus.done, bus.cpu_hold); end
        reset = 1'b1; step(); reset = 1'b0; step();
    endtask

    task automatic test_ignored_start();
        int hs, gap_bad;
        bit to;
        clear_mon();
        pulse_start(2);
        feed(1'b0, 1'b1, hs, gap_bad, to);
        checks++; if (to !== 1'b0 || hs !== 2 || wr_cnt !== 8 || last_addr !== 64'd7) begin
            errors++; $display("FAIL ign_start: timeout=%b words=%0d writes=%0d last=%0d expected 0/2/8/7", to, hs, wr_cnt, last_addr); end
    endtask

    task automatic test_checksum();
        int hs, gap_bad;
        bit to;
        logic [31:0] exp;
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp = 32'h009008A6;
`else
        exp = 32'h00000000;
`endif
        clear_mon();
        pulse_start(2);
        feed(1'b1, 1'b0, hs, gap_bad, to);
        checks++; if (to !== 1'b0 || bus.checksum !== exp || mem[4] !== 8'h93 || mem[1] !== 8'h04) begin
            errors++; $display("FAIL checksum: timeout=%b sum=%h m4=%h m1=%h expected 0/%h/93/04", to, bus.checksum, mem[4], mem[1], exp); end
    endtask

    task automatic test_reset_midload();
        bit found;
        found = 1'b0;
        pulse_start(5);
        for (int c = 0; c < 200; c++) begin
            if (bus.wr_en === 1'b1 && bus.wr_addr == 64'd10) begin
                found = 1'b1;
                break;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = 32'hA5A5A5A5;
            step();
        end
        checks++; if (found !== 1'b1) begin
            errors++; $display("FAIL midload_reach: reached_addr10=%b expected 1", found); end
        reset = 1'b1;
        #1;
        checks++; if (bus.wr_en !== 1'b0 || bus.cpu_hold !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
                      bus.wr_addr !== 64'd0 || bus.wr_byte !== 8'd0 || bus.in_ready !== 1'b0 || bus.checksum !== 32'd0) begin
            errors++; $display("FAIL midload_reset: wr_en=%b hold=%b busy=%b done=%b addr=%0d byte=%h ready=%b sum=%h expected 0/1/0/0/0/00/0/0",
                               bus.wr_en, bus.cpu_hold, bus.busy, bus.done, bus.wr_addr, bus.wr_byte, bus.in_ready, bus.checksum); end
        bus.in_valid = 1'b0;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.word_count = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        clear_mon();
        test_reset();
        test_zero_count();
        test_single_word();
        test_full_image();
        test_overflow();
        test_ignored_start();
        test_checksum();
        test_reset_midload();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the byte-addressed instruction memory. It accepts 32-bit instruction words over a valid/ready stream and emits one little-endian byte write per cycle, starting at address 0. It holds the pipeline in reset until the program image is fully written. It sits between the off-chip program source (testbench or UART front end) and the write port of a writable instruction memory.

## Interface
Parameters:
- MEM_BYTES, 168: capacity of the instruction memory in bytes; must be a multiple of 4.
- CNT_W, 16: width of the word counter and `word_count`.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a load; sampled only in IDLE or DONE.
- word_count  in  CNT_W  number of 32-bit words to load; sampled on the `start` cycle.
- in_valid  in  1  `in_data` is valid.
- in_ready  out  1  loader can accept a word this cycle.
- in_data  in  32  instruction word; bits [7:0] go to the lowest address.
- wr_en  out  1  byte write strobe to the instruction memory.
- wr_addr  out  64  byte address of the current write.
- wr_byte  out  8  byte to write.
- busy  out  1  load in progress.
- done  out  1  load finished; held until the next `start` or reset.
- err  out  1  overflow: the requested words exceed MEM_BYTES.
- cpu_hold  out  1  holds the processor in reset while high.
- checksum  out  32  running sum of accepted words (see Configuration).

## Operation
- States:
  - IDLE (after reset).
  - WAIT_WORD.
  - WRITE: four sub-cycles, indexed by a 2-bit byte index `bi`.
  - DONE.
- Reset values:
  - state=IDLE; in_ready=0; wr_en=0; wr_addr=0; wr_byte=0.
  - busy=0; done=0; err=0; cpu_hold=1; checksum=0.
  - Word counter and byte address are cleared to 0.
- IDLE or DONE, with `start`=1:
  - Latch `word_count`; clear the address, err, done and checksum.
  - cpu_hold=1.
  - If `word_count`==0, go to DONE; otherwise go to WAIT_WORD.
- WAIT_WORD:
  - `in_ready`=1 only when the next word fits, i.e. addr+4 <= MEM_BYTES.
  - If it does not fit, go to DONE with err=1; no handshake takes place.
  - On `in_valid`&&`in_ready`: latch the word, add it to the checksum, and go to WRITE with bi=0.
- WRITE:
  - Each cycle: wr_en=1, wr_addr=addr, wr_byte=word[8*bi+7:8*bi]; then addr+=1 and bi+=1.
  - After bi==3, decrement the remaining-word count. Go to DONE if it reaches 0, else back to WAIT_WORD.
- DONE: done=1, cpu_hold=0, busy=0. A new `start` re-enters the load sequence.
- busy=1 in WAIT_WORD and WRITE.
- `start` is ignored in WAIT_WORD and WRITE.
- Address arithmetic is 64-bit unsigned, with no wrap inside MEM_BYTES; the overflow check above precedes every word.
- Asserting `reset` mid-load aborts immediately to the reset values. Partial writes already issued stay in memory.

## Timing
- Registered outputs: wr_en, wr_addr, wr_byte, busy, done, err, cpu_hold, checksum.
- `in_ready` is a combinational decode of the state and the address compare.
- Handshake at cycle N ⇒ byte writes at the outputs in cycles N+1 through N+4 (addr, addr+1, addr+2, addr+3).
- Sustained throughput: one word per 5 cycles with `in_valid` held high.
- Last write at cycle M ⇒ done=1 and cpu_hold=0 from cycle M+1.
- `start` with word_count=0 at cycle N ⇒ done=1 from cycle N+1; no writes.
- `in_data` need only be stable in the handshake cycle.
- The source may hold `in_valid` high with no `in_ready`; nothing is consumed.

## Configuration
- Macro `IMEM_LOADER_CHECKSUM_EN`.
- Defined: `checksum` accumulates the 32-bit modulo-2^32 sum of every accepted word. It is cleared on reset and on `start`, and is valid once done=1.
- Undefined: the accumulator logic is omitted and `checksum` is driven to constant 0. The port list is unchanged.

## Test plan
- Single word: start with word_count=1, in_data=0x00000013 ⇒
  - writes (0,0x13), (1,0x00), (2,0x00), (3,0x00) on 4 consecutive cycles;
  - done=1 and cpu_hold=0 on the next cycle.
- Full image: word_count=42 with MEM_BYTES=168 and back-to-back valid ⇒
  - 168 writes, the last at wr_addr=167;
  - err=0; 5 cycles per word.
- Overflow: word_count=43 ⇒
  - 42 words written; in_ready never rises for the 43rd;
  - done=1, err=1, cpu_hold=0.
- Zero count and ignored start:
  - word_count=0 ⇒ done on the next cycle, no wr_en.
  - A `start` pulse during WRITE does not change the state or the counter.
- Reset mid-load: assert reset during bi=2 of word 3 ⇒ all outputs return to their reset values that cycle (cpu_hold=1, wr_en=0).
- With `IMEM_LOADER_CHECKSUM_EN` defined: load 0x00900413, 0x00000493 ⇒ checksum=0x009008A6 at done.
